adsr_envelope: RTL and testbench

//   ADSR amplitude envelope for the tone path. Sits between the notes ROM / note-change

---
 rtl/adsr_envelope_if.sv | 23 ++
 rtl/adsr_envelope.sv | 136 +++++++++++++
 tb/tb_adsr_envelope.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
// Note-event and envelope-output bundle between the note sequencer, the ADSR block and the PWM modulator.
interface adsr_envelope_if #(
  parameter int BW        = 24,
  parameter int ENV_WIDTH = 8
);
  logic                 note_on_i;
  logic                 note_off_i;
  logic [BW-1:0]        period_i;
  logic [BW-1:0]        duty_o;
  logic [ENV_WIDTH-1:0] level_o;
  logic [2:0]           state_o;
  logic                 busy_o;

  modport master (
    output note_on_i, note_off_i, period_i,
    input  duty_o, level_o, state_o, busy_o
  );

  modport slave (
    input  note_on_i, note_off_i, period_i,
    output duty_o, level_o, state_o, busy_o
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: steps a saturating level on a prescaled tick and scales the note's
// PWM period by it; all outputs registered, duty follows level/period with one cycle of latency.
module adsr_envelope #(
  parameter int BW            = 24,
  parameter int ENV_WIDTH     = 8,
  parameter int TICK_DIV      = 24000,
  parameter int ATTACK_STEP   = 16,
  parameter int DECAY_STEP    = 4,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 8
) (
  input  logic            clk_i,
  input  logic            rst,
  adsr_envelope_if.slave  env
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam int EW1      = ENV_WIDTH + 1;
  localparam int LMAX_INT = (1 << ENV_WIDTH) - 1;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Steps are clamped to LMAX so the (ENV_WIDTH+1)-bit add/sub can never wrap.
  localparam int A_CLAMP = (ATTACK_STEP  > LMAX_INT) ? LMAX_INT : ATTACK_STEP;
  localparam int D_CLAMP = (DECAY_STEP   > LMAX_INT) ? LMAX_INT : DECAY_STEP;
  localparam int R_CLAMP = (RELEASE_STEP > LMAX_INT) ? LMAX_INT : RELEASE_STEP;

  localparam logic [ENV_WIDTH:0] LMAX    = EW1'(LMAX_INT);
  localparam logic [ENV_WIDTH:0] A_STEP  = EW1'(A_CLAMP);
  localparam logic [ENV_WIDTH:0] D_STEP  = EW1'(D_CLAMP);
  localparam logic [ENV_WIDTH:0] R_STEP  = EW1'(R_CLAMP);
  localparam logic [ENV_WIDTH:0] S_LEVEL = EW1'(SUSTAIN_LEVEL);
  localparam logic [CW-1:0]      TICK_LAST = CW'(TICK_DIV - 1);

  state_e                 state_q, state_d;
  logic [ENV_WIDTH-1:0]   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          duty_q, duty_d;
  logic                   busy_q, busy_d;

  logic                   tick;
  logic [ENV_WIDTH:0]     lvl_ext;
  logic [ENV_WIDTH:0]     att_sum;
  logic [ENV_WIDTH:0]     dec_diff;
  logic [ENV_WIDTH:0]     dec_sat;
  logic [ENV_WIDTH:0]     rel_sat;
  logic [BW+ENV_WIDTH-1:0] prod;

  assign tick = (cnt_q == TICK_LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (env.note_on_i || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    lvl_ext  = {1'b0, level_q};
    att_sum  = lvl_ext + A_STEP;
    dec_diff = lvl_ext - D_STEP;
    dec_sat  = ((lvl_ext < D_STEP) || (dec_diff < S_LEVEL)) ? S_LEVEL : dec_diff;
    rel_sat  = (lvl_ext <= R_STEP) ? '0 : (lvl_ext - R_STEP);

    state_d = state_q;
    level_d = level_q;

    // Pulses take priority over the tick so a transition never also steps the level.
    if (env.note_on_i) begin
      state_d = ATTACK;
    end else if (env.note_off_i &&
                 (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        ATTACK: begin
          if (att_sum >= LMAX) begin
            level_d = LMAX[ENV_WIDTH-1:0];
            state_d = DECAY;
          end else begin
            level_d = att_sum[ENV_WIDTH-1:0];
          end
        end
        DECAY: begin
          level_d = dec_sat[ENV_WIDTH-1:0];
          if (dec_sat == S_LEVEL) begin
            state_d = SUSTAIN;
          end
        end
        RELEASE: begin
          level_d = rel_sat[ENV_WIDTH-1:0];
          if (rel_sat == '0) begin
            state_d = IDLE;
          end
        end
        default: begin
          level_d = level_q;
        end
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    prod   = {{ENV_WIDTH{1'b0}}, env.period_i} * {{BW{1'b0}}, level_q};
    duty_d = BW'(prod >> (ENV_WIDTH + 1));
  end

  assign env.level_o = level_q;
  assign env.state_o = state_q;
  assign env.busy_o  = busy_q;
  assign env.duty_o  = duty_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed table-driven bench for adsr_envelope with a 4-cycle tick and hand-computed levels/duties.
module tb_adsr_envelope;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;

  int checks = 0;
  int errors = 0;

  adsr_envelope_if #(.BW(24), .ENV_WIDTH(8)) bus();

  adsr_envelope #(
    .BW(24), .ENV_WIDTH(8), .TICK_DIV(4), .ATTACK_STEP(64),
    .DECAY_STEP(16), .SUSTAIN_LEVEL(128), .RELEASE_STEP(32)
  ) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .env   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic on;
    logic off;
    int   per;
    int   cyc;
    int   lvl;
    int   st;
    int   duty;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic on, input logic off, input int per, input int cyc,
                     input int lvl, input int st, input int duty);
    vec_t v;
    v.on = on; v.off = off; v.per = per; v.cyc = cyc;
    v.lvl = lvl; v.st = st; v.duty = duty;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int row, input int lvl, input int st,
                         input int duty);
    chk({tag, " level"}, row, {24'b0, bus.level_o}, lvl);
    chk({tag, " state"}, row, {29'b0, bus.state_o}, st);
    chk({tag, " duty"},  row, {8'b0, bus.duty_o},   duty);
    chk({tag, " busy"},  row, {31'b0, bus.busy_o},  (st != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    bus.note_on_i  = 1'b0;
    bus.note_off_i = 1'b0;
    bus.period_i   = 24'd200;

    // Attack 0->255 in four ticks, decay to the 128 clamp in eight, then duty 50.
    add(1, 0, 200, 1,   0, 1,  0);
    add(0, 0, 200, 4,  64, 1,  0);
    add(0, 0, 200, 4, 128, 1, 25);
    add(0, 0, 200, 4, 192, 1, 50);
    add(0, 0, 200, 4, 255, 2, 75);
    add(0, 0, 200, 4, 239, 2, 99);
    add(0, 0, 200, 4, 223, 2, 93);
    add(0, 0, 200, 4, 207, 2, 87);
    add(0, 0, 200, 4, 191, 2, 80);
    add(0, 0, 200, 4, 175, 2, 74);
    add(0, 0, 200, 4, 159, 2, 68);
    add(0, 0, 200, 4, 143, 2, 62);
    add(0, 0, 200, 4, 128, 3, 55);
    add(0, 0, 200, 1, 128, 3, 50);
    // Release from sustain down to idle.
    add(0, 1, 200, 3,  96, 4, 50);
    add(0, 0, 200, 4,  64, 4, 37);
    add(0, 0, 200, 4,  32, 4, 25);
    add(0, 0, 200, 4,   0, 0, 12);
    add(0, 0, 200, 1,   0, 0,  0);
    add(0, 1, 200, 1,   0, 0,  0);
    // New note, note_off in attack at 128, then retrigger during release at 64.
    add(1, 0, 200, 4,   0, 1,  0);
    add(0, 0, 200, 1,  64, 1,  0);
    add(0, 0, 200, 4, 128, 1, 25);
    add(0, 1, 200, 4,  96, 4, 50);
    add(0, 0, 200, 4,  64, 4, 37);
    add(1, 0, 200, 1,  64, 1, 25);
    add(0, 0, 200, 3,  64, 1, 25);
    add(0, 0, 200, 1, 128, 1, 25);
    add(0, 0, 200, 4, 192, 1, 50);
    add(0, 0, 200, 4, 255, 2, 75);
    add(0, 0, 200, 1, 255, 2, 99);
    // Period change tracked, same-cycle on+off, attack re-saturating at LMAX.
    add(0, 0, 100, 1, 255, 2, 49);
    add(1, 1, 100, 1, 255, 1, 49);
    add(0, 0, 100, 4, 255, 2, 49);
    add(0, 0, 100, 3, 255, 2, 49);
    // note_off landing on a tick edge: transition only, level not stepped.
    add(0, 1, 100, 1, 255, 4, 49);
    add(0, 0, 100, 4, 223, 4, 49);

    repeat (3) @(posedge clk_i);
    #1;
    chk_all("reset", -1, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.note_on_i  = vecs[i].on;
      bus.note_off_i = vecs[i].off;
      bus.period_i   = 24'(vecs[i].per);
      for (int c = 0; c < vecs[i].cyc; c++) begin
        @(posedge clk_i);
        #1;
        bus.note_on_i  = 1'b0;
        bus.note_off_i = 1'b0;
      end
      chk_all("vec", i, vecs[i].lvl, vecs[i].st, vecs[i].duty);
    end

    // Asynchronous reset mid-release must clear outputs before the next clock edge.
    rst = 1'b1;
    #1;
    chk_all("async_rst", -2, 0, 0, 0);
    @(posedge clk_i);
    #1;
    rst = 1'b0;
    chk_all("post_rst", -3, 0, 0, 0);
    repeat (5) @(posedge clk_i);
    #1;
    chk_all("idle_hold", -4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
